// File: rtl/conv_pkg.sv
// Shared types for the convolution MAC engine.
//   engine_state_e : engine FSM states
//   tap_tag_t      : valid/first/last tag that travels beside each tap in the pipeline
//   acc_width()    : accumulator width that holds F_SIZE full-precision products
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } engine_state_e;

  // Tap tag. The first tap of an output restarts the sum. The last tap of an
  // output marks the point where the finished sum is ready to publish.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tap_tag_t;

  // A sum of F_SIZE products, each 2*D_WIDTH bits wide, grows by at most
  // clog2(F_SIZE) bits.
  function automatic int acc_width(input int d_width, input int f_size);
    return 2 * d_width + $clog2(f_size);
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Multiply/accumulate back end of the convolution engine.
//   S2: registers the signed product of the x and f samples read in S1.
//   S3: acc_q += sign-extended product. The first tap of an output replaces acc_q instead.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   flush            clears the accumulator and drops the in-flight tag
//   in_tag           tag of the tap whose memory data is on x_data/f_data (S1)
//   x_data, f_data   signed samples returned by the memories
//   acc_next         accumulator value being written this cycle
//   sum_done         the last tap of an output is being accumulated this cycle
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int D_WIDTH   = 8,
  parameter int ACC_WIDTH = 21
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  tap_tag_t                    in_tag,
  input  logic signed [D_WIDTH-1:0]   x_data,
  input  logic signed [D_WIDTH-1:0]   f_data,
  output logic signed [ACC_WIDTH-1:0] acc_next,
  output logic                        sum_done
);

  localparam int P_WIDTH = 2 * D_WIDTH;

  tap_tag_t                    s2_tag_d, s2_tag_q;
  logic signed [P_WIDTH-1:0]   prod_d, prod_q;
  logic signed [ACC_WIDTH-1:0] prod_ext, acc_base, acc_d, acc_q;

  // NOTE: every always_comb output gets a value before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    s2_tag_d = flush ? '0 : in_tag;
    prod_d   = P_WIDTH'(x_data) * P_WIDTH'(f_data);
    prod_ext = {{(ACC_WIDTH - P_WIDTH){prod_q[P_WIDTH-1]}}, prod_q};
    acc_base = s2_tag_q.first ? '0 : acc_q;
    acc_d    = acc_q;
    if (flush) begin
      acc_d = '0;
    end else if (s2_tag_q.valid) begin
      acc_d = acc_base + prod_ext;
    end
    sum_done = s2_tag_q.valid && s2_tag_q.last && !flush;
  end

  assign acc_next = acc_d;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_tag_q <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
    end else begin
      s2_tag_q <= s2_tag_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Convolution datapath engine: y[k] = sum_j x[base+j] * f[j], j = 0..F_SIZE-1.
// It walks F_SIZE taps through a read/multiply/accumulate pipeline. It publishes
// y_data with a one-cycle conv_start pulse. After each accepted output, it slides
// the circular x window by one sample.
// Optional build macro: CONV_MAC_RELU_EN clamps negative results to zero.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   xmem_full, fmem_ready  start condition: x window and filter are loaded
//   y_accept               output consumed and next x sample written (acted on in HOLD only)
//   conv_done              end of vector: return to IDLE and rewind base
//   xmem_addr, fmem_addr   read addresses; memories return data one cycle later
//   xmem_data, fmem_data   signed read data
//   y_data                 signed result, held until the next conv_start
//   conv_start             one-cycle pulse in the cycle y_data changes
// The latency is F_SIZE+2 cycles. Cycle 0 is the first cycle in RUN.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int   X_MEM_ADDR_WIDTH = 5,
  parameter int   F_SIZE           = 32,
  parameter int   D_WIDTH          = 8,
  localparam int  ACC_WIDTH        = acc_width(D_WIDTH, F_SIZE),
  localparam int  TAP_WIDTH        = $clog2(F_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        xmem_full,
  input  logic                        fmem_ready,
  input  logic                        y_accept,
  input  logic                        conv_done,
  output logic [X_MEM_ADDR_WIDTH-1:0] xmem_addr,
  output logic [TAP_WIDTH-1:0]        fmem_addr,
  input  logic [D_WIDTH-1:0]          xmem_data,
  input  logic [D_WIDTH-1:0]          fmem_data,
  output logic signed [ACC_WIDTH-1:0] y_data,
  output logic                        conv_start
);

  localparam logic [TAP_WIDTH-1:0] TAP_LAST = TAP_WIDTH'(F_SIZE - 1);

  engine_state_e                 state_d, state_q;
  logic [TAP_WIDTH-1:0]          tap_d, tap_q;
  logic [X_MEM_ADDR_WIDTH-1:0]   base_d, base_q;
  tap_tag_t                      s1_tag_d, s1_tag_q;
  logic signed [ACC_WIDTH-1:0]   y_data_d, y_data_q;
  logic                          conv_start_d, conv_start_q;
  logic signed [ACC_WIDTH-1:0]   mac_sum;
  logic                          mac_done;
  logic signed [ACC_WIDTH-1:0]   y_result;

  // The x address wraps naturally at the circular buffer depth.
  assign xmem_addr  = base_q + X_MEM_ADDR_WIDTH'(tap_q);
  assign fmem_addr  = tap_q;
  assign y_data     = y_data_q;
  assign conv_start = conv_start_q;

`ifdef CONV_MAC_RELU_EN
  assign y_result = mac_sum[ACC_WIDTH-1] ? '0 : mac_sum;
`else
  assign y_result = mac_sum;
`endif

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    base_d       = base_q;
    s1_tag_d     = '0;
    y_data_d     = y_data_q;
    conv_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (xmem_full && fmem_ready) begin
          state_d = RUN;
          tap_d   = '0;
        end
      end
      RUN: begin
        // The tag enters S1 together with the read issued this cycle.
        s1_tag_d.valid = 1'b1;
        s1_tag_d.first = (tap_q == '0);
        s1_tag_d.last  = (tap_q == TAP_LAST);
        if (tap_q == TAP_LAST) begin
          tap_d   = '0;
          state_d = DRAIN;
        end else begin
          tap_d = tap_q + TAP_WIDTH'(1);
        end
      end
      DRAIN: begin
        // Publish from the accumulator's next value. This saves a cycle
        // compared with waiting for acc_q.
        if (mac_done) begin
          y_data_d     = y_result;
          conv_start_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (y_accept) begin
          base_d  = base_q + X_MEM_ADDR_WIDTH'(1);
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // conv_done overrides any state, including a y_accept in the same cycle.
    // The held y_data is left unchanged.
    if (conv_done) begin
      state_d      = IDLE;
      tap_d        = '0;
      base_d       = '0;
      s1_tag_d     = '0;
      y_data_d     = y_data_q;
      conv_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      base_q       <= '0;
      s1_tag_q     <= '0;
      y_data_q     <= '0;
      conv_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      base_q       <= base_d;
      s1_tag_q     <= s1_tag_d;
      y_data_q     <= y_data_d;
      conv_start_q <= conv_start_d;
    end
  end

  conv_mac_unit #(
    .D_WIDTH   (D_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .flush    (conv_done),
    .in_tag   (s1_tag_q),
    .x_data   (xmem_data),
    .f_data   (fmem_data),
    .acc_next (mac_sum),
    .sum_done (mac_done)
  );

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed testbench for conv_mac_engine.
// Two instances are used:
//   dut_a: F_SIZE=4 with a 32-deep x buffer, for the latency, sliding-window,
//          wrap, abort and reset scenarios.
//   dut_b: the default F_SIZE=32, for the full-scale and negative-result sums.
// The x and f memories are behavioural models with one cycle of read latency.
module tb_conv_mac_engine;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int A_F   = 4;
  localparam int B_F   = 32;
  localparam int A_ACC = 2 * DW + 2;
  localparam int B_ACC = 2 * DW + 5;
`ifdef CONV_MAC_RELU_EN
  localparam int B_NEG_EXP = 0;
`else
  localparam int B_NEG_EXP = -32;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                    a_xmem_full, a_fmem_ready, a_y_accept, a_conv_done;
  logic [AW-1:0]           a_xmem_addr;
  logic [1:0]              a_fmem_addr;
  logic [DW-1:0]           a_xmem_data, a_fmem_data;
  logic signed [A_ACC-1:0] a_y_data;
  logic                    a_conv_start;

  logic                    b_xmem_full, b_fmem_ready, b_y_accept, b_conv_done;
  logic [AW-1:0]           b_xmem_addr;
  logic [4:0]              b_fmem_addr;
  logic [DW-1:0]           b_xmem_data, b_fmem_data;
  logic signed [B_ACC-1:0] b_y_data;
  logic                    b_conv_start;

  logic signed [DW-1:0] a_xm [32];
  logic signed [DW-1:0] a_fm [A_F];
  logic signed [DW-1:0] b_xm [32];
  logic signed [DW-1:0] b_fm [B_F];

  conv_mac_engine #(.X_MEM_ADDR_WIDTH(AW), .F_SIZE(A_F), .D_WIDTH(DW)) dut_a (
    .clk(clk), .reset(reset),
    .xmem_full(a_xmem_full), .fmem_ready(a_fmem_ready),
    .y_accept(a_y_accept), .conv_done(a_conv_done),
    .xmem_addr(a_xmem_addr), .fmem_addr(a_fmem_addr),
    .xmem_data(a_xmem_data), .fmem_data(a_fmem_data),
    .y_data(a_y_data), .conv_start(a_conv_start)
  );

  conv_mac_engine #(.X_MEM_ADDR_WIDTH(AW), .F_SIZE(B_F), .D_WIDTH(DW)) dut_b (
    .clk(clk), .reset(reset),
    .xmem_full(b_xmem_full), .fmem_ready(b_fmem_ready),
    .y_accept(b_y_accept), .conv_done(b_conv_done),
    .xmem_addr(b_xmem_addr), .fmem_addr(b_fmem_addr),
    .xmem_data(b_xmem_data), .fmem_data(b_fmem_data),
    .y_data(b_y_data), .conv_start(b_conv_start)
  );

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    a_xmem_data <= a_xm[a_xmem_addr];
    a_fmem_data <= a_fm[a_fmem_addr];
    b_xmem_data <= b_xm[b_xmem_addr];
    b_fmem_data <= b_fm[b_fmem_addr];
  end

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until conv_start is seen. The search is bounded, so a
  // missing pulse shows up as n = 100.
  task automatic wait_a(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (a_conv_start !== 1'b1 && n < 100);
  endtask

  task automatic wait_b(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (b_conv_start !== 1'b1 && n < 100);
  endtask

  // Reference sum for dut_a at a given window base.
  function automatic int a_model(input int base);
    int s = 0;
    for (int j = 0; j < A_F; j++) s += int'(a_xm[(base + j) % 32]) * int'(a_fm[j]);
    return s;
  endfunction

  initial begin
    int n;
    int pulses;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    a_xmem_full = 0; a_fmem_ready = 0; a_y_accept = 0; a_conv_done = 0;
    b_xmem_full = 0; b_fmem_ready = 0; b_y_accept = 0; b_conv_done = 0;
    for (int i = 0; i < 32; i++) begin
      a_xm[i] = DW'(i + 1);
      b_xm[i] = -8'sd128;
      b_fm[i] = -8'sd128;
    end
    for (int j = 0; j < A_F; j++) a_fm[j] = 8'sd1;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset xmem_addr", a_xmem_addr, 0);
    check("reset fmem_addr", a_fmem_addr, 0);
    check("reset y_data", a_y_data, 0);
    check("reset conv_start", a_conv_start, 0);
    check("reset b y_data", b_y_data, 0);
    check("reset b conv_start", b_conv_start, 0);

    // Full-scale sum: 32 * (-128 * -128) = 524288.
    b_fmem_ready = 1; b_xmem_full = 1;
    tick();
    b_xmem_full = 0;
    wait_b(n);
    check("b full-scale latency", n, B_F + 2);
    check("b full-scale y", b_y_data, 524288);
    tick();
    check("b conv_start one cycle", b_conv_start, 0);
    check("b y held in HOLD", b_y_data, 524288);
    b_conv_done = 1;
    tick();
    b_conv_done = 0;
    check("b y kept after conv_done", b_y_data, 524288);

    // Negative sum: 32 * (1 * -1) = -32. RELU builds clamp it to 0.
    for (int i = 0; i < 32; i++) begin
      b_xm[i] = 8'sd1;
      b_fm[i] = -8'sd1;
    end
    b_xmem_full = 1;
    tick();
    b_xmem_full = 0;
    wait_b(n);
    check("b negative latency", n, B_F + 2);
    check("b negative y", b_y_data, B_NEG_EXP);
    b_conv_done = 1;
    tick();
    b_conv_done = 0;

    // x = 1,2,3,4 and f = 1,1,1,1 give y = 10, with conv_start 6 cycles after start.
    a_fmem_ready = 1; a_xmem_full = 1;
    tick();
    a_xmem_full = 0;
    wait_a(n);
    check("a start latency", n, 6);
    check("a sum 1..4", a_y_data, 10);
    tick();
    check("a conv_start one cycle", a_conv_start, 0);
    check("a y held", a_y_data, 10);
    a_conv_done = 1;
    tick();
    a_conv_done = 0;

    // f = 1,0,0,-1, so y = x[base] - x[base+3], which is -3 away from the wrap.
    a_fm[0] = 8'sd1; a_fm[1] = 8'sd0; a_fm[2] = 8'sd0; a_fm[3] = -8'sd1;
    a_xmem_full = 1;
    tick();
    a_xmem_full = 0;
    check("a tap0 xmem_addr", a_xmem_addr, 0);
    tick();
    check("a tap1 xmem_addr", a_xmem_addr, 1);
    check("a tap1 fmem_addr", a_fmem_addr, 1);
    wait_a(n);
    check("a diff latency", n, 5);
    check("a diff y base0", a_y_data, -3);

    // Slide the window 32 times. Base 29..31 wraps the address past 31
    // (y = 29), and base returns to 0 at the end.
    for (int k = 1; k <= 32; k++) begin
      int b;
      b = k % 32;
      a_y_accept = 1;
      tick();
      a_y_accept = 0;
      check($sformatf("slide base %0d tap0 addr", b), a_xmem_addr, b);
      repeat (3) tick();
      check($sformatf("slide base %0d tap3 addr", b), a_xmem_addr, (b + 3) % 32);
      check($sformatf("slide base %0d tap3 faddr", b), a_fmem_addr, 3);
      wait_a(n);
      check($sformatf("slide base %0d latency", b), n, 3);
      check($sformatf("slide base %0d y", b), a_y_data, a_model(b));
      if (k == 1) check("second y hand value", a_y_data, -3);
      if (k == 29) check("wrap y hand value", a_y_data, 29);
    end

    // y_accept held high through RUN and DRAIN must not move base again.
    a_y_accept = 1;
    tick();
    check("accept to base 1", a_xmem_addr, 1);
    repeat (5) tick();
    a_y_accept = 0;
    wait_a(n);
    check("accept-ignored latency", n, 1);
    check("accept-ignored y", a_y_data, a_model(1));
    a_y_accept = 1;
    tick();
    a_y_accept = 0;
    check("base advanced only once", a_xmem_addr, 2);
    wait_a(n);
    check("base 2 latency", n, 6);
    check("base 2 y", a_y_data, a_model(2));

    // conv_done together with y_accept: conv_done wins and base goes to 0.
    a_y_accept = 1; a_conv_done = 1;
    tick();
    a_y_accept = 0; a_conv_done = 0;
    check("done+accept xmem_addr", a_xmem_addr, 0);
    check("done+accept fmem_addr", a_fmem_addr, 0);
    check("done+accept conv_start", a_conv_start, 0);
    check("done+accept y kept", a_y_data, -3);
    a_xmem_full = 1;
    tick();
    a_xmem_full = 0;
    tick();
    check("restart base 0 tap1 addr", a_xmem_addr, 1);

    // Abort mid-RUN: back to IDLE at once, and no conv_start follows.
    a_conv_done = 1;
    tick();
    a_conv_done = 0;
    check("abort xmem_addr", a_xmem_addr, 0);
    check("abort fmem_addr", a_fmem_addr, 0);
    pulses = 0;
    repeat (10) begin
      tick();
      if (a_conv_start === 1'b1) pulses++;
    end
    check("abort no conv_start", pulses, 0);

    // A fresh start after the abort gives a clean sum.
    for (int j = 0; j < A_F; j++) a_fm[j] = 8'sd1;
    a_xmem_full = 1;
    tick();
    a_xmem_full = 0;
    wait_a(n);
    check("fresh latency", n, 6);
    check("fresh y", a_y_data, 10);

    // Reset during DRAIN: all outputs return to 0, and no conv_start follows.
    a_y_accept = 1;
    tick();
    a_y_accept = 0;
    repeat (4) tick();
    check("pre-reset in DRAIN no pulse", a_conv_start, 0);
    reset = 1;
    tick();
    reset = 0;
    check("drain reset xmem_addr", a_xmem_addr, 0);
    check("drain reset fmem_addr", a_fmem_addr, 0);
    check("drain reset y_data", a_y_data, 0);
    check("drain reset conv_start", a_conv_start, 0);
    check("drain reset b y_data", b_y_data, 0);
    pulses = 0;
    repeat (10) begin
      tick();
      if (a_conv_start === 1'b1) pulses++;
    end
    check("post-reset no conv_start", pulses, 0);
    check("post-reset y stays 0", a_y_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
